onehot_decoder: RTL

ONEHOT_DECODER -- requirements
Module: onehot_decoder

---
 rtl/dsd_pkg.sv | 12 +
 rtl/dwell_counter.sv | 27 ++
 rtl/onehot_decoder.sv | 104 ++++++++++
 3 files changed

// File: rtl/dsd_pkg.sv
// rtl/dsd_pkg.sv - shared FSM state encodings and counter width for the decoder slice
package dsd_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/dwell_counter.sv
// rtl/dwell_counter.sv - loadable down-counter shared by the HOLD and GAP dwell phases
module dwell_counter
  import dsd_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/onehot_decoder.sv
// rtl/onehot_decoder.sv - registered one-hot decoder holding each word for a fixed dwell, then a gap
module onehot_decoder
  import dsd_pkg::*;
#(
  parameter int CODE_W      = 2,
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CODE_W-1:0]    in_code,
  input  logic                 in_none,
  output logic [2**CODE_W-1:0] out_onehot,
  output logic                 out_valid,
  output logic [7:0]           xfer_count
);

  localparam int OUT_W = 2**CODE_W;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t           state, state_nxt;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_val;
  logic             xfer, leave_hold;

  // Held low through reset so the source never sees a spurious accept.
  assign in_ready = rst_n && (state == IDLE);
  assign xfer     = (state == IDLE) && in_valid;

  dwell_counter u_dwell (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_load   = 1'b0;
    cnt_val    = '0;
    cnt_dec    = 1'b0;
    leave_hold = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_nxt = HOLD;
          cnt_load  = 1'b1;
          cnt_val   = HOLD_LOAD;
        end
      end
      HOLD: begin
        if (cnt_zero) begin
          leave_hold = 1'b1;
          if (GAP_CYCLES > 0) begin
            state_nxt = GAP;
            cnt_load  = 1'b1;
            cnt_val   = GAP_LOAD;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      GAP: begin
        if (cnt_zero) begin
          state_nxt = IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_onehot <= '0;
      out_valid  <= 1'b0;
      xfer_count <= '0;
    end else if (xfer) begin
      out_onehot <= in_none ? '0 : (OUT_W'(1) << in_code);
      out_valid  <= 1'b1;
      xfer_count <= xfer_count + 8'd1;
    end else if (leave_hold) begin
      out_onehot <= '0;
      out_valid  <= 1'b0;
    end
  end

endmodule
